spi_ram_bus_bridge: RTL and testbench

- Upstream front end for spi_ram_controller. Converts a valid/ready request channel and a valid/ready response channel into the controller's single-cycle start_read/start_write pulse and busy-wait protocol.
- Captures each request, launches exactly one controller transaction, waits for completion, then returns read data or a write acknowledge.
- One transaction outstanding at a time. Sits between the core/bus fabric and the controller instance.

---
 rtl/spi_ram_bus_bridge.sv | 130 +++++++++++++
 tb/tb_spi_ram_bus_bridge.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ram_bus_bridge.sv
// spi_ram_bus_bridge: valid/ready request/response front end for spi_ram_controller, one transaction outstanding.
// Optional one-word read-ahead buffer enabled by defining SPI_RAM_PREFETCH_EN.
module spi_ram_bus_bridge #(
  parameter int DATA_WIDTH_BYTES = 4,
  parameter int ADDR_BITS = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_write,
  input  logic [ADDR_BITS-1:0]          req_addr,
  input  logic [DATA_WIDTH_BYTES*8-1:0] req_wdata,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_WIDTH_BYTES*8-1:0] rsp_rdata,
  output logic [ADDR_BITS-1:0]          ctrl_addr,
  output logic [DATA_WIDTH_BYTES*8-1:0] ctrl_wdata,
  output logic                          ctrl_start_read,
  output logic                          ctrl_start_write,
  input  logic [DATA_WIDTH_BYTES*8-1:0] ctrl_rdata,
  input  logic                          ctrl_busy
);
  localparam int DW = DATA_WIDTH_BYTES * 8;
  localparam logic [2:0] IDLE = 3'd0, ISSUE = 3'd1, WAIT = 3'd2, RESP = 3'd3;
`ifdef SPI_RAM_PREFETCH_EN
  localparam logic [2:0] PF_ISSUE = 3'd4, PF_WAIT = 3'd5;
  localparam logic [ADDR_BITS-1:0] STEP = ADDR_BITS'(DATA_WIDTH_BYTES);
`endif
  logic [2:0] state_q, state_d;
  logic wr_q, wr_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
`ifdef SPI_RAM_PREFETCH_EN
  logic pf_valid_q, pf_valid_d;
  logic [ADDR_BITS-1:0] pf_tag_q, pf_tag_d;
  logic [DW-1:0] pf_data_q, pf_data_d;
  logic [ADDR_BITS-1:0] diff_up, diff_dn;
  logic overlap, hit;
  // modular distance in both directions catches overlap across the address wrap
  assign diff_up = req_addr - pf_tag_q;
  assign diff_dn = pf_tag_q - req_addr;
  assign overlap = pf_valid_q && (diff_up < STEP || diff_dn < STEP);
  assign hit = pf_valid_q && !req_write && req_addr == pf_tag_q;
  assign ctrl_start_read = (state_q == ISSUE && !wr_q) || state_q == PF_ISSUE;
`else
  assign ctrl_start_read = state_q == ISSUE && !wr_q;
`endif
  assign ctrl_start_write = state_q == ISSUE && wr_q;
  assign req_ready = state_q == IDLE;
  assign rsp_valid = state_q == RESP;
  assign rsp_rdata = rdata_q;
  assign ctrl_addr = addr_q;
  assign ctrl_wdata = wdata_q;
  always_comb begin
    state_d = state_q;
    wr_d = wr_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef SPI_RAM_PREFETCH_EN
    pf_valid_d = pf_valid_q;
    pf_tag_d = pf_tag_q;
    pf_data_d = pf_data_q;
`endif
    case (state_q)
      IDLE: if (req_valid) begin
        wr_d = req_write;
        addr_d = req_addr;
        wdata_d = req_wdata;
        state_d = ISSUE;
`ifdef SPI_RAM_PREFETCH_EN
        if (req_write && overlap) pf_valid_d = 1'b0;
        if (hit) begin
          rdata_d = pf_data_q;
          state_d = RESP;
        end
`endif
      end
      ISSUE: state_d = WAIT;
      WAIT: if (!ctrl_busy) begin
        rdata_d = wr_q ? rdata_q : ctrl_rdata;
        state_d = RESP;
      end
      RESP: if (rsp_ready) begin
`ifdef SPI_RAM_PREFETCH_EN
        state_d = wr_q ? IDLE : PF_ISSUE;
        addr_d = wr_q ? addr_q : addr_q + STEP;
`else
        state_d = IDLE;
`endif
      end
`ifdef SPI_RAM_PREFETCH_EN
      PF_ISSUE: state_d = PF_WAIT;
      PF_WAIT: if (!ctrl_busy) begin
        pf_valid_d = 1'b1;
        pf_tag_d = addr_q;
        pf_data_d = ctrl_rdata;
        state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wr_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef SPI_RAM_PREFETCH_EN
      pf_valid_q <= 1'b0;
      pf_tag_q <= '0;
      pf_data_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      wr_q <= wr_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef SPI_RAM_PREFETCH_EN
      pf_valid_q <= pf_valid_d;
      pf_tag_q <= pf_tag_d;
      pf_data_q <= pf_data_d;
`endif
    end
  end
endmodule

// File: tb/tb_spi_ram_bus_bridge.sv
// tb_spi_ram_bus_bridge: directed bench with a transaction-level model, a busy-wait controller model and literal pins.
module tb_spi_ram_bus_bridge;
  localparam int AB = 16;
  localparam int NB = 4;
  localparam int BUSY_CYC = 8 + AB + 8 * NB;
  localparam int LAT = BUSY_CYC + 3;
`ifdef SPI_RAM_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [15:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic rsp_valid, rsp_ready = 1'b0;
  logic [31:0] rsp_rdata, ctrl_wdata, ctrl_rdata;
  logic [15:0] ctrl_addr;
  logic ctrl_start_read, ctrl_start_write, ctrl_busy;

  spi_ram_bus_bridge #(.DATA_WIDTH_BYTES(NB), .ADDR_BITS(AB)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .ctrl_addr(ctrl_addr), .ctrl_wdata(ctrl_wdata),
    .ctrl_start_read(ctrl_start_read), .ctrl_start_write(ctrl_start_write),
    .ctrl_rdata(ctrl_rdata), .ctrl_busy(ctrl_busy));

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input logic [15:0] a);
    return a == 16'h1234 ? 32'hDEADBEEF : {a ^ 16'h5A5A, ~a};
  endfunction

  // controller: busy rises the cycle after a start pulse and stays up for BUSY_CYC cycles
  logic [31:0] cm_mem [65536];
  bit cm_wr [65536];
  int cm_cnt;
  logic cm_op;
  logic [15:0] cm_a;
  logic [31:0] cm_d;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_busy <= 1'b0;
      ctrl_rdata <= '0;
      cm_cnt <= 0;
    end else if (ctrl_busy) begin
      if (cm_cnt == 1) begin
        ctrl_busy <= 1'b0;
        if (cm_op) begin
          cm_mem[cm_a] <= cm_d;
          cm_wr[cm_a] <= 1'b1;
        end else ctrl_rdata <= cm_wr[cm_a] ? cm_mem[cm_a] : pat(cm_a);
      end
      cm_cnt <= cm_cnt - 1;
    end else if (ctrl_start_read || ctrl_start_write) begin
      ctrl_busy <= 1'b1;
      cm_cnt <= BUSY_CYC;
      cm_op <= ctrl_start_write;
      cm_a <= ctrl_addr;
      cm_d <= ctrl_wdata;
    end
  end

  int checks = 0, fails = 0, cyc = 0;
  int acc_cnt = 0, hs_cnt = 0, tmo = 0, tmo_rep = 0;
  bit pin_en = 1'b0;
  logic [31:0] pin_rd = '0;
  int pin_lat = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  bit pend = 0, got = 0, hit = 0, pf_v = 0;
  logic pend_w;
  logic [15:0] pend_a, pf_t = '0;
  logic [31:0] pend_d, exp_rd, exp_last = '0;
  int acc_cyc, exp_lat, pulses, last_lat;
  logic [31:0] exp_mem [65536];
  bit exp_wr [65536];

  function automatic logic [31:0] mval(input logic [15:0] a);
    return exp_wr[a] ? exp_mem[a] : pat(a);
  endfunction

  function automatic bit overlaps(input logic [15:0] a, input logic [15:0] t);
    logic [15:0] d1, d2;
    d1 = a - t;
    d2 = t - a;
    return d1 < 16'(NB) || d2 < 16'(NB);
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (tmo != tmo_rep) begin
      tmo_rep = tmo;
      chk("handshake_timeout", 32'(tmo), 32'(tmo - 1));
    end
    if (rst) begin
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_starts", {30'd0, ctrl_start_read, ctrl_start_write}, 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_ctrl_addr", 32'(ctrl_addr), 32'd0);
      chk("rst_ctrl_wdata", ctrl_wdata, 32'd0);
      pend = 0;
      got = 0;
      pf_v = 0;
      exp_last = '0;
    end else begin
      if (pend && !got && rsp_valid) begin
        got = 1;
        last_lat = cyc - acc_cyc;
        chk("rsp_latency", 32'(last_lat), 32'(exp_lat));
        chk("start_pulses", 32'(pulses), hit ? 32'd0 : 32'd1);
      end
      if (pend && !got && cyc - acc_cyc == exp_lat + 1) chk("rsp_missing", 32'(rsp_valid), 32'd1);
      if (got) begin
        chk("rsp_valid_held", 32'(rsp_valid), 32'd1);
        chk("rsp_rdata", rsp_rdata, exp_rd);
      end
      if (!pend) chk("rsp_spurious", 32'(rsp_valid), 32'd0);
      if (pend) chk("req_ready_busy", 32'(req_ready), 32'd0);
`ifndef SPI_RAM_PREFETCH_EN
      else chk("req_ready_idle", 32'(req_ready), 32'd1);
`endif
      if (ctrl_start_read || ctrl_start_write) begin
        chk("start_while_busy", 32'(ctrl_busy), 32'd0);
        chk("start_both", 32'(ctrl_start_read && ctrl_start_write), 32'd0);
        if (pend) begin
          pulses++;
          chk("start_kind", 32'(ctrl_start_write), 32'(pend_w));
          chk("ctrl_addr", 32'(ctrl_addr), 32'(pend_a));
          if (pend_w) chk("ctrl_wdata", ctrl_wdata, pend_d);
        end else begin
`ifdef SPI_RAM_PREFETCH_EN
          chk("pf_start_read", 32'(ctrl_start_read && pf_v), 32'd1);
          chk("pf_addr", 32'(ctrl_addr), 32'(pf_t));
`else
          chk("unsolicited_start", 32'd1, 32'd0);
`endif
        end
      end
      if (pend && got && rsp_valid && rsp_ready) begin
        hs_cnt++;
        if (pin_en) begin
          chk("pin_rdata", rsp_rdata, pin_rd);
          chk("pin_latency", 32'(last_lat), 32'(pin_lat));
        end
        exp_last = exp_rd;
        if (!pend_w) begin
          pf_t = pend_a + 16'(NB);
          pf_v = PF;
        end
        pend = 0;
        got = 0;
      end else if (!pend && req_valid && req_ready) begin
        acc_cnt++;
        pend = 1;
        got = 0;
        pulses = 0;
        acc_cyc = cyc;
        pend_w = req_write;
        pend_a = req_addr;
        pend_d = req_wdata;
        if (req_write) begin
          hit = 0;
          exp_rd = exp_last;
          exp_lat = LAT;
          exp_mem[req_addr] = req_wdata;
          exp_wr[req_addr] = 1'b1;
          if (overlaps(req_addr, pf_t)) pf_v = 0;
        end else begin
          hit = pf_v && pf_t == req_addr;
          exp_rd = mval(req_addr);
          exp_lat = hit ? 1 : LAT;
        end
      end
    end
  end

  task automatic xfer(input logic w, input logic [15:0] a, input logic [31:0] d, input int hold);
    int n;
    n = acc_cnt;
    req_write = w;
    req_addr = a;
    req_wdata = d;
    req_valid = 1'b1;
    for (int i = 0; i < 400 && acc_cnt == n; i++) begin @(posedge clk); #1; end
    req_valid = 1'b0;
    if (acc_cnt == n) tmo++;
    for (int i = 0; i < 200 && !rsp_valid; i++) begin @(posedge clk); #1; end
    if (hold > 0) begin
      req_valid = 1'b1;
      req_addr = 16'h0BAD;
      repeat (hold) begin @(posedge clk); #1; end
      req_valid = 1'b0;
    end
    n = hs_cnt;
    rsp_ready = 1'b1;
    for (int i = 0; i < 200 && hs_cnt == n; i++) begin @(posedge clk); #1; end
    rsp_ready = 1'b0;
    if (hs_cnt == n) tmo++;
  endtask

  task automatic pin(input logic [31:0] rd, input int lat);
    pin_rd = rd;
    pin_lat = lat;
    pin_en = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    pin(32'hDEADBEEF, 59);
    xfer(1'b0, 16'h1234, 32'h0, 0);
    pin(32'hDEADBEEF, 59);
    xfer(1'b1, 16'h0010, 32'hCAFEF00D, 0);
    pin(32'hCAFEF00D, 59);
    xfer(1'b0, 16'h0010, 32'h0, 10);
    pin_en = 1'b0;
    req_write = 1'b0;
    req_addr = 16'h3000;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    xfer(1'b0, 16'h2000, 32'h0, 0);
    xfer(1'b1, 16'h2000, 32'h12345678, 0);
    pin(32'h12345678, 59);
    xfer(1'b0, 16'h2000, 32'h0, 0);
    pin_en = 1'b0;
`ifdef SPI_RAM_PREFETCH_EN
    xfer(1'b0, 16'hFFFC, 32'h0, 0);
    pin(32'h5A5AFFFF, 1);
    xfer(1'b0, 16'h0000, 32'h0, 0);
    pin_en = 1'b0;
    xfer(1'b0, 16'h0100, 32'h0, 0);
    xfer(1'b1, 16'h0104, 32'h0BADF00D, 0);
    pin(32'h0BADF00D, 59);
    xfer(1'b0, 16'h0104, 32'h0, 0);
    pin_en = 1'b0;
`endif
    repeat (100) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
